// File: rtl/debounce_onepulse.sv
// ---------------------------------------------------------------------------
// debounce_onepulse
//   Debounces NUM_BTN raw pushbuttons. The buttons are sampled on the rising
//   edges of a slow square wave. Each channel reports its debounced level,
//   one-clk press and release pulses, and a single one-clk long-press pulse.
//
// Ports
//   clk           system clock, the only clock in the block
//   rst_n         asynchronous active-low reset
//   clk_debounce  slow square wave from the divider, sampled as data
//   btn_in        raw asynchronous buttons, active-high          [NUM_BTN]
//   btn_level     debounced button level                         [NUM_BTN]
//   btn_press     one-clk pulse on debounced 0->1                [NUM_BTN]
//   btn_release   one-clk pulse on debounced 1->0                [NUM_BTN]
//   btn_long      one-clk pulse when a press lasts LONG_TICKS    [NUM_BTN]
// ---------------------------------------------------------------------------
module debounce_onepulse #(
    parameter int NUM_BTN    = 4,
    parameter int DB_SAMPLES = 4,
    parameter int LONG_TICKS = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_debounce,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long
);

    localparam int                CNT_W   = $clog2(LONG_TICKS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(LONG_TICKS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    // Hold counter increment that saturates at LONG_TICKS instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic               cd_p0, cd_p1, cd_p2;
    logic [NUM_BTN-1:0] btn_p0, btn_p1;
    logic               tick;

    // Stage p0/p1: two-flop synchronizers; p2 holds the previous divider level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cd_p0  <= 1'b0;
            cd_p1  <= 1'b0;
            cd_p2  <= 1'b0;
            btn_p0 <= '0;
            btn_p1 <= '0;
        end else begin
            cd_p0  <= clk_debounce;
            cd_p1  <= cd_p0;
            cd_p2  <= cd_p1;
            btn_p0 <= btn_in;
            btn_p1 <= btn_p0;
        end
    end

    // Rising edge of the synchronized divider only; falling edges are ignored.
    assign tick = cd_p1 & ~cd_p2;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        logic [DB_SAMPLES-1:0] hist;
        logic                  level;
        logic                  level_d;
        logic                  press_q;
        logic                  release_q;
        logic                  long_q;
        logic                  rise;
        state_t                state, state_nxt;
        logic [CNT_W-1:0]      cnt, cnt_nxt;
        logic                  long_nxt;

        // Stage: sample history and debounced level. Everything here only
        // moves on tick, so a stalled divider freezes the channel.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hist  <= '0;
                level <= 1'b0;
            end else begin
                if (tick) begin
                    hist <= {hist[DB_SAMPLES-2:0], btn_p1[g]};
                end
                if (&hist) begin
                    level <= 1'b1;
                end else if (~|hist) begin
                    level <= 1'b0;
                end
            end
        end

        assign rise = level & ~level_d;

        // Stage: edge pulses and press-state machine, all registered.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                level_d   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                state     <= IDLE;
                cnt       <= '0;
            end else begin
                level_d   <= level;
                press_q   <= rise;
                release_q <= ~level & level_d;
                long_q    <= long_nxt;
                state     <= state_nxt;
                cnt       <= cnt_nxt;
            end
        end

        // A falling level always wins over reaching the long-press count, so
        // a release never carries a long pulse with it.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            long_nxt  = 1'b0;
            case (state)
                IDLE: begin
                    cnt_nxt = '0;
                    if (rise) begin
                        state_nxt = PRESSED;
                    end
                end
                PRESSED: begin
                    if (!level) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_MAX) begin
                        state_nxt = HELD;
                        long_nxt  = 1'b1;
                    end else if (tick) begin
                        cnt_nxt = sat_inc(cnt);
                    end
                end
                HELD: begin
                    if (!level) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        assign btn_level[g]   = level;
        assign btn_press[g]   = press_q;
        assign btn_release[g] = release_q;
        assign btn_long[g]    = long_q;
    end

endmodule

// File: tb/tb_debounce_onepulse.sv
// ---------------------------------------------------------------------------
// tb_debounce_onepulse
//   Directed bench for debounce_onepulse with default parameters. A debounce
//   tick is one 8-clk period of clk_debounce (4 high, 4 low). A monitor counts
//   output pulses per channel; the directed sequence compares those counts and
//   the levels against hand-computed values.
// ---------------------------------------------------------------------------
module tb_debounce_onepulse;

    localparam int NB = 4;

    logic          clk;
    logic          rst_n;
    logic          clk_debounce;
    logic [NB-1:0] btn_in;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_long;

    debounce_onepulse #(
        .NUM_BTN   (NB),
        .DB_SAMPLES(4),
        .LONG_TICKS(64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_debounce(clk_debounce),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_press   [NB];
    int n_release [NB];
    int n_long    [NB];
    int press_cycles;
    int any_pulses;
    int lvl1_seen;
    logic [NB-1:0] last_press;

    int n_total;
    int n_pass;

    initial begin
        for (int i = 0; i < NB; i++) begin
            n_press[i]   = 0;
            n_release[i] = 0;
            n_long[i]    = 0;
        end
        press_cycles = 0;
        any_pulses   = 0;
        lvl1_seen    = 0;
        last_press   = '0;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NB; i++) begin
                if (btn_press[i])   n_press[i]++;
                if (btn_release[i]) n_release[i]++;
                if (btn_long[i])    n_long[i]++;
            end
            if (|btn_press) begin
                press_cycles++;
                last_press = btn_press;
            end
            if (|btn_press || |btn_release || |btn_long) any_pulses++;
            if (btn_level[1]) lvl1_seen++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One debounce tick: rising edge, 4 clk high, 4 clk low; ends on a negedge.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clk_debounce = 1'b1;
            repeat (4) @(negedge clk);
            clk_debounce = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    int snap_a, snap_b, snap_c;

    initial begin
        n_total      = 0;
        n_pass       = 0;
        rst_n        = 1'b0;
        clk_debounce = 1'b0;
        btn_in       = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_level",   btn_level,   0);
        check_eq("reset_press",   btn_press,   0);
        check_eq("reset_release", btn_release, 0);
        check_eq("reset_long",    btn_long,    0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean 100-tick press on channel 0.
        btn_in[0] = 1'b1;
        ticks(3);
        check_eq("ch0_no_press_3ticks", n_press[0], 0);
        ticks(1);
        check_eq("ch0_press_4ticks", n_press[0], 1);
        check_eq("ch0_level_high", btn_level[0], 1);
        ticks(63);
        check_eq("ch0_no_long_67ticks", n_long[0], 0);
        ticks(1);
        check_eq("ch0_long_68ticks", n_long[0], 1);
        ticks(32);
        check_eq("ch0_long_once", n_long[0], 1);
        check_eq("ch0_press_once", n_press[0], 1);
        btn_in[0] = 1'b0;
        ticks(3);
        check_eq("ch0_no_release_yet", n_release[0], 0);
        ticks(1);
        check_eq("ch0_release", n_release[0], 1);
        check_eq("ch0_level_low", btn_level[0], 0);
        ticks(2);

        // Channel 1 toggled every tick: nothing may come out.
        snap_a = any_pulses;
        snap_b = lvl1_seen;
        for (int i = 0; i < 20; i++) begin
            btn_in[1] = ~btn_in[1];
            ticks(1);
        end
        btn_in[1] = 1'b0;
        ticks(6);
        check_eq("ch1_level_never", lvl1_seen - snap_b, 0);
        check_eq("ch1_no_pulses", any_pulses - snap_a, 0);

        // Channel 2 short press: press and release, no long.
        btn_in[2] = 1'b1;
        ticks(10);
        btn_in[2] = 1'b0;
        ticks(6);
        check_eq("ch2_press", n_press[2], 1);
        check_eq("ch2_release", n_release[2], 1);
        check_eq("ch2_no_long", n_long[2], 0);

        // Channels 0 and 3 pressed in the same clk.
        snap_a = press_cycles;
        btn_in = 4'b1001;
        ticks(5);
        check_eq("dual_press_cycles", press_cycles - snap_a, 1);
        check_eq("dual_press_vec", last_press, 4'b1001);
        snap_b = n_release[0];
        snap_c = n_release[3];
        btn_in = 4'b0000;
        ticks(5);
        check_eq("dual_release_ch0", n_release[0] - snap_b, 1);
        check_eq("dual_release_ch3", n_release[3] - snap_c, 1);

        // Reset in the middle of a held press on channel 0.
        snap_a = n_press[0];
        btn_in[0] = 1'b1;
        ticks(30);
        check_eq("rst_pre_press", n_press[0] - snap_a, 1);
        check_eq("rst_pre_level", btn_level[0], 1);
        snap_b = n_release[0];
        snap_c = n_long[0];
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_level", btn_level, 0);
        check_eq("rst_async_pulses", {btn_press, btn_release, btn_long}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ticks(3);
        check_eq("rst_no_press_3ticks", n_press[0] - snap_a, 1);
        ticks(1);
        check_eq("rst_repress_4ticks", n_press[0] - snap_a, 2);
        check_eq("rst_no_release", n_release[0] - snap_b, 0);
        check_eq("rst_no_long", n_long[0] - snap_c, 0);
        btn_in[0] = 1'b0;
        ticks(6);

        // Stalled divider freezes the debouncer.
        snap_a = n_press[3];
        btn_in[3] = 1'b1;
        repeat (1000) @(negedge clk);
        check_eq("stall_level", btn_level[3], 0);
        check_eq("stall_no_press", n_press[3] - snap_a, 0);
        ticks(4);
        check_eq("resume_level", btn_level[3], 1);
        check_eq("resume_press", n_press[3] - snap_a, 1);
        btn_in[3] = 1'b0;
        ticks(6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
